// File: rtl/sensor_frame_pkg.sv
// Shared types and helpers for the sensor frame receiver.
// Build option: SENSOR_FRAME_CHKSUM_EN adds a trailing checksum byte per frame.
package sensor_frame_pkg;

    // Frame-level FSM
    typedef enum logic [1:0] {
        HUNT,
        COLLECT,
        CHK
    } state_t;

    // UART byte receiver FSM
    typedef enum logic [1:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP
    } ustate_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    // Bytes needed to carry one sample
    function automatic int bps(input int sample_w);
        return (sample_w + 7) / 8;
    endfunction

    // Byte index width for a frame of nch samples
    function automatic int idx_w(input int nch, input int sample_w);
        return $clog2(nch * bps(sample_w) + 1);
    endfunction

endpackage

// File: rtl/sensor_frame_rx_uart_byte_rx.sv
// 8N1 UART byte receiver: synchroniser, start-bit qualify, mid-bit sampling.
// A low stop bit drops the byte and pulses stop_err instead of byte_vld.
module uart_byte_rx
    import sensor_frame_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    output logic [7:0] byte_data,
    output logic       byte_vld,
    output logic       stop_err
);

    localparam int CW   = $clog2(BAUD_DIV);
    localparam int HALF = BAUD_DIV / 2;

    ustate_t       ustate;
    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bitn;
    logic [7:0]    shreg;

    // Synchronise the line, detect a falling edge, then sample each bit at its centre.
    // Hunting requires a high-to-low edge so a line stuck low after a bad stop bit
    // is not mistaken for a new start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            ustate    <= U_IDLE;
            cnt       <= '0;
            bitn      <= '0;
            shreg     <= '0;
            byte_data <= '0;
            byte_vld  <= 1'b0;
            stop_err  <= 1'b0;
        end else begin
            rx_meta  <= RX;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            byte_vld <= 1'b0;
            stop_err <= 1'b0;
            case (ustate)
                U_IDLE: begin
                    cnt <= '0;
                    if (rx_prev && !rx_sync) ustate <= U_START;
                end
                U_START: begin
                    if (cnt == CW'(HALF - 1)) begin
                        cnt  <= '0;
                        bitn <= '0;
                        // still low at mid start bit -> real start, otherwise a glitch
                        ustate <= rx_sync ? U_IDLE : U_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                U_DATA: begin
                    if (cnt == CW'(BAUD_DIV - 1)) begin
                        cnt   <= '0;
                        shreg <= {rx_sync, shreg[7:1]};
                        bitn  <= bitn + 3'd1;
                        if (bitn == 3'd7) ustate <= U_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                U_STOP: begin
                    if (cnt == CW'(BAUD_DIV - 1)) begin
                        cnt <= '0;
                        if (rx_sync) begin
                            byte_data <= shreg;
                            byte_vld  <= 1'b1;
                        end else begin
                            stop_err <= 1'b1;
                        end
                        ustate <= U_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ustate <= U_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sensor_frame_rx.sv
// Multi-channel sensor frame receiver: hunts SYNC_BYTE, collects NUM_CH big-endian
// samples into a shadow file and commits them to meas in one cycle.
// Build option: SENSOR_FRAME_CHKSUM_EN appends a two's-complement checksum byte.
module sensor_frame_rx
    import sensor_frame_pkg::*;
#(
    parameter int         BAUD_DIV  = 2604,
    parameter int         NUM_CH    = 3,
    parameter int         SAMPLE_W  = 14,
    parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
    parameter int         TIMEOUT   = 4 * 10 * BAUD_DIV
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       RX,
    output logic [NUM_CH*SAMPLE_W-1:0] meas,
    output logic                       frame_vld,
    output logic                       frame_err,
    output logic [7:0]                 err_cnt
);

    localparam int BPS    = bps(SAMPLE_W);
    localparam int NBYTES = NUM_CH * BPS;
    localparam int IDXW   = idx_w(NUM_CH, SAMPLE_W);
    localparam int TW     = $clog2(TIMEOUT + 1);
    localparam logic [IDXW-1:0] LAST  = IDXW'(NBYTES - 1);
    localparam logic [TW-1:0]   TLAST = TW'(TIMEOUT - 1);

    logic [7:0]                 rx_byte;
    logic                       byte_vld;
    logic                       stop_err;

    state_t                     state;
    logic [IDXW-1:0]            idx;
    logic [NBYTES-1:0][7:0]     shadow;
    logic [NBYTES-1:0][7:0]     shadow_in;
    logic [7:0]                 sum;
    logic [TW-1:0]              idle;
    logic [NUM_CH*SAMPLE_W-1:0] meas_in;
    logic [BPS*8-1:0]           word;
    logic                       chk_bad;
    logic                       drop;

    uart_byte_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .RX       (RX),
        .byte_data(rx_byte),
        .byte_vld (byte_vld),
        .stop_err (stop_err)
    );

    // Shadow file including the byte arriving this cycle, so the final byte can
    // be committed on the very edge that captures it.
    always_comb begin
        shadow_in = shadow;
        if (state == COLLECT && byte_vld) shadow_in[idx] = rx_byte;
    end

    // Assemble samples: first byte of a sample is MS, keep low SAMPLE_W bits.
    always_comb begin
        meas_in = '0;
        word    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int b = 0; b < BPS; b++) word[(BPS-1-b)*8 +: 8] = shadow_in[c*BPS+b];
            meas_in[c*SAMPLE_W +: SAMPLE_W] = word[SAMPLE_W-1:0];
        end
    end

    // Frame drop conditions; an arriving byte always beats timeout expiry.
    always_comb begin
        chk_bad = 1'b0;
`ifdef SENSOR_FRAME_CHKSUM_EN
        chk_bad = (state == CHK) && (8'(sum + rx_byte) != 8'd0);
`endif
        drop = (state != HUNT) && (byte_vld ? chk_bad : (stop_err || idle == TLAST));
    end

    // Frame FSM with index, running sum, idle timer, commit and error counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            idx       <= '0;
            shadow    <= '0;
            sum       <= '0;
            idle      <= '0;
            meas      <= '0;
            frame_vld <= 1'b0;
            frame_err <= 1'b0;
            err_cnt   <= '0;
        end else begin
            frame_vld <= 1'b0;
            frame_err <= 1'b0;
            if (drop) begin
                frame_err <= 1'b1;
                state     <= HUNT;
                idle      <= '0;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end else begin
                case (state)
                    HUNT: begin
                        idle <= '0;
                        if (byte_vld && rx_byte == SYNC_BYTE) begin
                            state <= COLLECT;
                            idx   <= '0;
                            sum   <= '0;
                        end
                    end
                    COLLECT: begin
                        if (byte_vld) begin
                            shadow <= shadow_in;
                            sum    <= sum + rx_byte;
                            idx    <= idx + IDXW'(1);
                            idle   <= '0;
                            if (idx == LAST) begin
`ifdef SENSOR_FRAME_CHKSUM_EN
                                state <= CHK;
`else
                                meas      <= meas_in;
                                frame_vld <= 1'b1;
                                state     <= HUNT;
`endif
                            end
                        end else begin
                            idle <= idle + TW'(1);
                        end
                    end
`ifdef SENSOR_FRAME_CHKSUM_EN
                    CHK: begin
                        // a bad checksum is handled by drop, so reaching here means it matched
                        if (byte_vld) begin
                            meas      <= meas_in;
                            frame_vld <= 1'b1;
                            state     <= HUNT;
                            idle      <= '0;
                        end else begin
                            idle <= idle + TW'(1);
                        end
                    end
`endif
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sensor_frame_rx.sv
// Directed bench for sensor_frame_rx with an expected-event scoreboard.
// Honours SENSOR_FRAME_CHKSUM_EN by appending checksum bytes to each frame.
module tb_sensor_frame_rx;

    localparam int BD = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RX  = 1'b1;
    logic [41:0] meas;
    logic        frame_vld;
    logic        frame_err;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_err;
        logic [41:0] meas;
        logic [7:0]  ecnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [41:0] meas_m = '0;
    logic [7:0]  ecnt_m = '0;

    sensor_frame_rx #(.BAUD_DIV(BD), .NUM_CH(3), .SAMPLE_W(14)) dut (
        .clk      (clk),
        .rst      (rst),
        .RX       (RX),
        .meas     (meas),
        .frame_vld(frame_vld),
        .frame_err(frame_err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        @(negedge clk);
        RX = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BD) @(negedge clk);
        end
        RX = stop;
        repeat (BD) @(negedge clk);
        RX = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // SYNC + six data bytes (+ checksum when enabled); chk_adj perturbs the checksum
    task automatic send_frame(input logic [7:0] d[6], input logic [7:0] chk_adj = 8'd0);
        logic [7:0] s;
        s = 8'd0;
        send_byte(8'hA5);
        for (int i = 0; i < 6; i++) begin
            send_byte(d[i]);
            s = s + d[i];
        end
`ifdef SENSOR_FRAME_CHKSUM_EN
        send_byte(8'd0 - s + chk_adj);
`endif
    endtask

    task automatic push_vld(input logic [41:0] m);
        exp_t e;
        meas_m = m;
        e.is_err = 1'b0; e.meas = m; e.ecnt = ecnt_m;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        ecnt_m = ecnt_m + 8'd1;
        e.is_err = 1'b1; e.meas = meas_m; e.ecnt = ecnt_m;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard: every output pulse must match the next expected event.
    always @(negedge clk) begin
        if (!rst && (frame_vld || frame_err)) begin
            exp_t e;
            chk("vld_err_exclusive", 64'(frame_vld && frame_err), 64'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {63'd0, frame_err}, {63'd0, frame_vld});
                chk("unexpected_pulse_any", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", 64'(frame_err), 64'(e.is_err));
                chk("event_meas", 64'(meas), 64'(e.meas));
                chk("event_err_cnt", 64'(err_cnt), 64'(e.ecnt));
            end
        end
    end

    localparam logic [41:0] M_A = {14'h0001, 14'h3FFF, 14'h1234};
    localparam logic [41:0] M_B = {14'h0007, 14'h2500, 14'h0123};

    initial begin
        logic [7:0] fa[6];
        logic [7:0] fb[6];
        fa = '{8'h12, 8'h34, 8'h3F, 8'hFF, 8'h00, 8'h01};
        fb = '{8'hC1, 8'h23, 8'hA5, 8'h00, 8'h00, 8'h07};

        // reset state
        repeat (5) @(negedge clk);
        chk("rst_meas", 64'(meas), 64'd0);
        chk("rst_vld", 64'(frame_vld), 64'd0);
        chk("rst_err", 64'(frame_err), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // basic frame
        push_vld(M_A);
        send_frame(fa);
        drain("frame_a");
        chk("meas_a_hold", 64'(meas), 64'(M_A));

        // reset for 3 cycles in the middle of a byte of a partial frame
        send_byte(8'hA5);
        send_byte(8'h12);
        RX = 1'b0;
        repeat (BD + 5) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_meas", 64'(meas), 64'd0);
        chk("midrst_err_cnt", 64'(err_cnt), 64'd0);
        chk("midrst_pulses", 64'(frame_vld | frame_err), 64'd0);
        rst = 1'b0;
        RX  = 1'b1;
        meas_m = '0;
        repeat (40) @(negedge clk);
        chk("post_rst_meas", 64'(meas), 64'd0);
        push_vld(M_A);
        send_frame(fa);
        drain("frame_after_rst");

        // leading garbage ignored
        send_byte(8'h00);
        send_byte(8'hFF);
        push_vld(M_A);
        send_frame(fa);
        drain("frame_garbage");

        // MS bits truncated, sync value inside data taken as data
        push_vld(M_B);
        send_frame(fb);
        drain("frame_trunc");

        // inter-byte timeout
        send_byte(8'hA5);
        send_byte(8'h12);
        send_byte(8'h34);
        push_err();
        repeat (10 * BD * 5) @(negedge clk);
        drain("timeout");
        chk("timeout_meas", 64'(meas), 64'(M_B));
        chk("timeout_err_cnt", 64'(err_cnt), 64'd1);
        push_vld(M_A);
        send_frame(fa);
        drain("frame_after_timeout");

`ifdef SENSOR_FRAME_CHKSUM_EN
        // wrong checksum (7A instead of 7B)
        push_err();
        send_frame(fa, 8'hFF);
        drain("bad_checksum");
        chk("badchk_meas", 64'(meas), 64'(M_A));
`endif

        // stop bit low in the middle of a frame
        send_byte(8'hA5);
        send_byte(8'h12);
        push_err();
        send_byte(8'h34, 1'b0);
        drain("stop_err");
        chk("stop_err_meas", 64'(meas), 64'(M_A));
        chk("stop_err_cnt", 64'(err_cnt), 64'(ecnt_m));

        // stop error while hunting is ignored, next frame still accepted
        send_byte(8'h55, 1'b0);
        push_vld(M_B);
        send_frame(fb);
        drain("frame_final");
        chk("final_meas", 64'(meas), 64'(meas_m));
        chk("final_err_cnt", 64'(err_cnt), 64'(ecnt_m));

        repeat (20) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
